// File: rtl/mem_stage_pkg.sv
// Shared encodings and widths for the memory pipeline stage.
package mem_stage_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned FLAG_W = 4;

  typedef enum logic [2:0] {
    OP_PASS       = 3'b000,
    OP_LOAD       = 3'b001,
    OP_STORE      = 3'b010,
    OP_PUSH       = 3'b011,
    OP_POP        = 3'b100,
    OP_POP_FLAGS  = 3'b101,
    OP_PUSH_FLAGS = 3'b110,
    OP_RSVD       = 3'b111
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  function automatic logic is_mem_op(input op_e op);
    return (op != OP_PASS) && (op != OP_RSVD);
  endfunction

  function automatic logic is_read_op(input op_e op);
    return (op == OP_LOAD) || (op == OP_POP) || (op == OP_POP_FLAGS);
  endfunction

endpackage

// File: rtl/memory_stage_stack_pointer.sv
// Stack pointer register; wraps modulo 2^ADDR_W.
module stack_pointer #(
  parameter int unsigned       ADDR_W  = 16,
  parameter logic [ADDR_W-1:0] SP_INIT = '1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  input  logic              dec,
  output logic [ADDR_W-1:0] sp,
  output logic [ADDR_W-1:0] sp_plus1
);

  assign sp_plus1 = sp + ADDR_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   sp <= SP_INIT;
    else if (inc) sp <= sp_plus1;
    else if (dec) sp <= sp - ADDR_W'(1);
  end

endmodule

// File: rtl/memory_stage.sv
// Memory stage: loads/stores/push/pop over a ready-handshaked port, owns sp.
module memory_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned       DATA_W  = mem_stage_pkg::DATA_W,
  parameter int unsigned       ADDR_W  = 16,
  parameter logic [ADDR_W-1:0] SP_INIT = '1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [2:0]        in_op,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_store_data,
  input  logic [FLAG_W-1:0] in_flags,
  input  logic [2:0]        in_rd,
  input  logic              in_wb_en,
  input  logic              flush,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_result,
  output logic [DATA_W-1:0] prev_mem,
  output logic [2:0]        out_rd,
  output logic              out_wb_en,
  output logic [FLAG_W-1:0] mem_flags,
  output logic              mem_flags_valid,
  output logic [ADDR_W-1:0] sp
);

  state_e            state;
  op_e               h_op;
  logic [DATA_W-1:0] h_alu;
  logic [2:0]        h_rd;
  logic              h_wb_en;
  logic              h_flushed;
  logic [ADDR_W-1:0] sp_plus1;
  op_e               op_in;
  logic              done;
  logic              kill;
  logic              sp_inc;
  logic              sp_dec;

  assign op_in    = op_e'(in_op);
  assign stall    = (state == ST_BUSY);
  assign prev_mem = out_result;
  assign done     = (state == ST_BUSY) && mem_ready;
  assign kill     = flush || h_flushed;
  assign sp_inc   = done && ((h_op == OP_POP)  || (h_op == OP_POP_FLAGS));
  assign sp_dec   = done && ((h_op == OP_PUSH) || (h_op == OP_PUSH_FLAGS));

  stack_pointer #(
    .ADDR_W (ADDR_W),
    .SP_INIT(SP_INIT)
  ) u_stack_pointer (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (sp_inc),
    .dec     (sp_dec),
    .sp      (sp),
    .sp_plus1(sp_plus1)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      h_op            <= OP_PASS;
      h_alu           <= '0;
      h_rd            <= '0;
      h_wb_en         <= 1'b0;
      h_flushed       <= 1'b0;
      mem_req         <= 1'b0;
      mem_we          <= 1'b0;
      mem_addr        <= '0;
      mem_wdata       <= '0;
      out_valid       <= 1'b0;
      out_result      <= '0;
      out_rd          <= '0;
      out_wb_en       <= 1'b0;
      mem_flags       <= '0;
      mem_flags_valid <= 1'b0;
    end else begin
      out_valid       <= 1'b0;
      mem_flags_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_valid && !flush) begin
            h_op      <= op_in;
            h_alu     <= in_alu_result;
            h_rd      <= in_rd;
            h_wb_en   <= in_wb_en;
            h_flushed <= 1'b0;
            if (!is_mem_op(op_in)) begin
              out_valid  <= 1'b1;
              out_result <= in_alu_result;
              out_rd     <= in_rd;
              out_wb_en  <= in_wb_en;
            end else begin
              state     <= ST_BUSY;
              mem_req   <= 1'b1;
              mem_we    <= !is_read_op(op_in);
              mem_wdata <= in_store_data;
              case (op_in)
                OP_PUSH:       mem_addr <= sp;
                OP_PUSH_FLAGS: begin
                  mem_addr  <= sp;
                  mem_wdata <= DATA_W'(in_flags);
                end
                OP_POP, OP_POP_FLAGS: mem_addr <= sp_plus1;
                default:       mem_addr <= ADDR_W'(in_alu_result);
              endcase
            end
          end
        end
        ST_BUSY: begin
          if (flush) h_flushed <= 1'b1;
          // A flushed access still finishes on the bus; only its visible pulses are killed.
          if (mem_ready) begin
            state      <= ST_IDLE;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            out_valid  <= !kill;
            out_rd     <= h_rd;
            out_result <= is_read_op(h_op) ? mem_rdata : h_alu;
            out_wb_en  <= is_read_op(h_op) && h_wb_en && !kill;
            if (h_op == OP_POP_FLAGS) begin
              mem_flags       <= mem_rdata[FLAG_W-1:0];
              mem_flags_valid <= !kill;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed table, randomized model run, corner sequences.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [2:0]  in_op;
  logic [15:0] in_alu_result;
  logic [15:0] in_store_data;
  logic [3:0]  in_flags;
  logic [2:0]  in_rd;
  logic        in_wb_en;
  logic        flush;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic        out_valid;
  logic [15:0] out_result;
  logic [15:0] prev_mem;
  logic [2:0]  out_rd;
  logic        out_wb_en;
  logic [3:0]  mem_flags;
  logic        mem_flags_valid;
  logic [15:0] sp;

  memory_stage #(
    .DATA_W (16),
    .ADDR_W (16),
    .SP_INIT(16'hFFFF)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_op          (in_op),
    .in_alu_result  (in_alu_result),
    .in_store_data  (in_store_data),
    .in_flags       (in_flags),
    .in_rd          (in_rd),
    .in_wb_en       (in_wb_en),
    .flush          (flush),
    .stall          (stall),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .mem_ready      (mem_ready),
    .out_valid      (out_valid),
    .out_result     (out_result),
    .prev_mem       (prev_mem),
    .out_rd         (out_rd),
    .out_wb_en      (out_wb_en),
    .mem_flags      (mem_flags),
    .mem_flags_valid(mem_flags_valid),
    .sp             (sp)
  );

  always #5 clk = ~clk;

  // Bus-side memory
  logic [15:0] mem_model [0:65535];
  assign mem_rdata = mem_model[mem_addr];
  always @(posedge clk) if (mem_req && mem_ready && mem_we) mem_model[mem_addr] <= mem_wdata;

  // Reference model state
  logic [15:0] ref_mem [0:65535];
  int unsigned ref_sp;
  logic [3:0]  ref_flags;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] alu;
    logic [15:0] sd;
    logic [3:0]  flags;
    logic [2:0]  rd;
    logic        wb;
    int unsigned waits;
    logic [15:0] exp_res;
    logic        exp_wb;
    logic [15:0] exp_addr;
    logic        exp_we;
    logic [15:0] exp_wdata;
    logic [15:0] exp_sp;
    logic [3:0]  exp_flags;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic vec_t mk(input logic [2:0] op, input logic [15:0] alu, input logic [15:0] sd,
                              input logic [3:0] fl, input logic [2:0] rd, input logic wb,
                              input int unsigned waits, input logic [15:0] res, input logic ewb,
                              input logic [15:0] addr, input logic we, input logic [15:0] wd,
                              input logic [15:0] esp, input logic [3:0] efl);
    vec_t v;
    v.op = op; v.alu = alu; v.sd = sd; v.flags = fl; v.rd = rd; v.wb = wb; v.waits = waits;
    v.exp_res = res; v.exp_wb = ewb; v.exp_addr = addr; v.exp_we = we; v.exp_wdata = wd;
    v.exp_sp = esp; v.exp_flags = efl;
    return v;
  endfunction

  // Architectural behaviour in plain arithmetic: stack grows down, sp points at the next free slot.
  task automatic model(input logic [2:0] op, input logic [15:0] alu, input logic [15:0] sd,
                       input logic [3:0] fl, input logic [2:0] rd, input logic wb,
                       input int unsigned waits, output vec_t v);
    v = mk(op, alu, sd, fl, rd, wb, waits, alu, wb, 16'h0, 1'b0, 16'h0, 16'h0, 4'h0);
    case (op)
      3'd1: begin v.exp_addr = alu; v.exp_res = ref_mem[alu]; end
      3'd2: begin
        v.exp_addr = alu; v.exp_we = 1; v.exp_wdata = sd; v.exp_wb = 0; ref_mem[alu] = sd;
      end
      3'd3, 3'd6: begin
        v.exp_addr = 16'(ref_sp); v.exp_we = 1; v.exp_wb = 0;
        v.exp_wdata = (op == 3'd3) ? sd : {12'h000, fl};
        ref_mem[16'(ref_sp)] = v.exp_wdata;
        ref_sp = (ref_sp + 65535) % 65536;
      end
      3'd4, 3'd5: begin
        ref_sp = (ref_sp + 1) % 65536;
        v.exp_addr = 16'(ref_sp); v.exp_res = ref_mem[16'(ref_sp)];
        if (op == 3'd5) ref_flags = v.exp_res[3:0];
      end
      default: ;
    endcase
    v.exp_sp = 16'(ref_sp);
    v.exp_flags = ref_flags;
  endtask

  task automatic apply(input vec_t v);
    logic is_mem;
    is_mem = (v.op != 3'd0) && (v.op != 3'd7);
    @(negedge clk);
    chk("stall_before_accept", stall, 0);
    in_valid = 1; in_op = v.op; in_alu_result = v.alu; in_store_data = v.sd;
    in_flags = v.flags; in_rd = v.rd; in_wb_en = v.wb;
    @(posedge clk); #1;
    in_valid = 0;
    if (is_mem) begin
      for (int k = 0; k <= int'(v.waits); k++) begin
        @(negedge clk);
        chk("busy_stall", stall, 1);
        chk("busy_mem_req", mem_req, 1);
        chk("busy_mem_we", mem_we, v.exp_we);
        chk("busy_mem_addr", mem_addr, v.exp_addr);
        if (v.exp_we) chk("busy_mem_wdata", mem_wdata, v.exp_wdata);
        chk("busy_no_out_valid", out_valid, 0);
        chk("busy_no_flags_valid", mem_flags_valid, 0);
        mem_ready = (k == int'(v.waits));
        @(posedge clk); #1;
      end
      mem_ready = 0;
    end
    chk("done_out_valid", out_valid, 1);
    chk("done_stall", stall, 0);
    chk("done_mem_req", mem_req, 0);
    chk("done_out_result", out_result, v.exp_res);
    chk("done_prev_mem", prev_mem, v.exp_res);
    chk("done_out_rd", out_rd, v.rd);
    chk("done_out_wb_en", out_wb_en, v.exp_wb);
    chk("done_sp", sp, v.exp_sp);
    chk("done_mem_flags", mem_flags, v.exp_flags);
    chk("done_flags_valid", mem_flags_valid, (v.op == 3'd5));
  endtask

  task automatic flush_run(input logic [2:0] op, input logic [15:0] alu, input logic [15:0] exp_sp);
    @(negedge clk);
    in_valid = 1; in_op = op; in_alu_result = alu; in_store_data = 16'h5A5A; in_rd = 3'd1; in_wb_en = 1;
    @(posedge clk); #1;
    in_valid = 0;
    @(negedge clk);
    chk("flush_busy_stall", stall, 1);
    flush = 1;
    @(posedge clk); #1;
    flush = 0;
    @(negedge clk);
    chk("flush_latched_busy", stall, 1);
    chk("flush_mem_req_held", mem_req, 1);
    mem_ready = 1;
    @(posedge clk); #1;
    mem_ready = 0;
    chk("flush_no_out_valid", out_valid, 0);
    chk("flush_no_wb", out_wb_en, 0);
    chk("flush_stall_clear", stall, 0);
    chk("flush_sp", sp, exp_sp);
    @(posedge clk); #1;
    chk("flush_no_late_valid", out_valid, 0);
  endtask

  vec_t vecs[10];
  vec_t rv;

  initial begin
    for (int i = 0; i < 65536; i++) begin mem_model[i] = '0; ref_mem[i] = '0; end
    ref_sp = 32'hFFFF; ref_flags = 4'h0;
    in_valid = 0; in_op = 0; in_alu_result = 0; in_store_data = 0; in_flags = 0;
    in_rd = 0; in_wb_en = 0; flush = 0; mem_ready = 0;
    rst_n = 1;
    #2 rst_n = 0;
    #10;
    chk("rst_stall", stall, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_prev_mem", prev_mem, 0);
    chk("rst_mem_flags_valid", mem_flags_valid, 0);
    chk("rst_sp", sp, 16'hFFFF);
    @(negedge clk); rst_n = 1;

    //               op    alu      sd       fl    rd  wb w  res      ewb addr     we wdata    sp       flg
    vecs[0] = mk(3'd0, 16'h1234, 16'h0000, 4'h0, 3, 1, 0, 16'h1234, 1, 16'h0000, 0, 16'h0000, 16'hFFFF, 4'h0);
    vecs[1] = mk(3'd2, 16'h0010, 16'hBEEF, 4'h0, 1, 1, 2, 16'h0010, 0, 16'h0010, 1, 16'hBEEF, 16'hFFFF, 4'h0);
    vecs[2] = mk(3'd1, 16'h0010, 16'h0000, 4'h0, 5, 1, 0, 16'hBEEF, 1, 16'h0010, 0, 16'h0000, 16'hFFFF, 4'h0);
    vecs[3] = mk(3'd3, 16'h0007, 16'hAAAA, 4'h0, 6, 1, 1, 16'h0007, 0, 16'hFFFF, 1, 16'hAAAA, 16'hFFFE, 4'h0);
    vecs[4] = mk(3'd4, 16'h0000, 16'h0000, 4'h0, 2, 1, 0, 16'hAAAA, 1, 16'hFFFF, 0, 16'h0000, 16'hFFFF, 4'h0);
    vecs[5] = mk(3'd6, 16'h0003, 16'h0000, 4'hA, 0, 1, 0, 16'h0003, 0, 16'hFFFF, 1, 16'h000A, 16'hFFFE, 4'h0);
    vecs[6] = mk(3'd5, 16'h0000, 16'h0000, 4'h0, 4, 1, 3, 16'h000A, 1, 16'hFFFF, 0, 16'h0000, 16'hFFFF, 4'hA);
    vecs[7] = mk(3'd7, 16'h5555, 16'h0000, 4'h0, 7, 0, 0, 16'h5555, 0, 16'h0000, 0, 16'h0000, 16'hFFFF, 4'hA);
    vecs[8] = mk(3'd4, 16'h0000, 16'h0000, 4'h0, 1, 1, 0, 16'h0000, 1, 16'h0000, 0, 16'h0000, 16'h0000, 4'hA);
    vecs[9] = mk(3'd3, 16'h0000, 16'h1357, 4'h0, 0, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h1357, 16'hFFFF, 4'hA);

    for (int i = 0; i < 10; i++) begin
      model(vecs[i].op, vecs[i].alu, vecs[i].sd, vecs[i].flags, vecs[i].rd, vecs[i].wb, vecs[i].waits, rv);
      apply(vecs[i]);
    end

    for (int i = 0; i < 40; i++) begin
      logic [2:0]  op;
      logic [15:0] alu;
      op  = 3'($urandom_range(0, 7));
      alu = ((op == 3'd1) || (op == 3'd2)) ? 16'(16'h0100 + $urandom_range(0, 15)) : 16'($urandom);
      model(op, alu, 16'($urandom), 4'($urandom), 3'($urandom), 1'($urandom),
            $urandom_range(0, 3), rv);
      apply(rv);
    end

    // mem_ready asserted while idle must be ignored
    @(negedge clk); mem_ready = 1;
    @(posedge clk); @(posedge clk); #1;
    chk("idle_ready_no_valid", out_valid, 0);
    chk("idle_ready_stall", stall, 0);
    chk("idle_ready_sp", sp, 16'(ref_sp));
    mem_ready = 0;

    // flush in IDLE blocks acceptance
    @(negedge clk);
    in_valid = 1; flush = 1; in_op = 3'd1; in_alu_result = 16'h0010;
    @(posedge clk); #1;
    in_valid = 0; flush = 0;
    chk("idle_flush_no_accept", stall, 0);
    chk("idle_flush_no_req", mem_req, 0);
    chk("idle_flush_no_valid", out_valid, 0);

    flush_run(3'd1, 16'h0010, 16'(ref_sp));
    flush_run(3'd3, 16'h0000, 16'((ref_sp + 65535) % 65536));
    ref_sp = (ref_sp + 65535) % 65536;

    // reset while BUSY drops the request asynchronously
    @(negedge clk);
    in_valid = 1; in_op = 3'd3; in_store_data = 16'h7777;
    @(posedge clk); #1;
    in_valid = 0;
    chk("pre_rst_busy", mem_req, 1);
    #2 rst_n = 0;
    #1;
    chk("rst_mid_mem_req", mem_req, 0);
    chk("rst_mid_stall", stall, 0);
    chk("rst_mid_sp", sp, 16'hFFFF);
    chk("rst_mid_out_valid", out_valid, 0);
    @(negedge clk); rst_n = 1;
    @(posedge clk); @(posedge clk); #1;
    chk("post_rst_sp", sp, 16'hFFFF);
    chk("post_rst_idle", stall, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
Pipeline stage directly downstream of execute; consumes the 16-bit ALU result and the 4-bit flags execute produces. Performs loads, stores, pushes and pops over a ready-handshaked data-memory port and owns the stack pointer. Returns prev_mem (the forwarding operand) and mem_flags (flags restored from the stack) to execute. Stalls upstream while a memory access is outstanding.

Parameters:
DATA_W, 16, data/result width.
ADDR_W, 16, memory address width; the stack pointer wraps modulo 2^ADDR_W.
SP_INIT, 16'hFFFF, stack pointer value after reset.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
in_valid  in  1  instruction presented by execute.
in_op  in  3  000 PASS, 001 LOAD, 010 STORE, 011 PUSH, 100 POP, 101 POP_FLAGS, 110 PUSH_FLAGS, 111 treated as PASS.
in_alu_result  in  DATA_W  ALU_out; the address for LOAD/STORE, the result for PASS.
in_store_data  in  DATA_W  STORE/PUSH write data.
in_flags  in  4  execute output_flags; the PUSH_FLAGS payload.
in_rd  in  3  destination register.
in_wb_en  in  1  writeback enable.
flush  in  1  synchronous kill.
stall  out  1  upstream must hold its inputs.
mem_req, mem_we  out  1 each  memory request and write enable.
mem_addr  out  ADDR_W.
mem_wdata  out  DATA_W.
mem_rdata  in  DATA_W.
mem_ready  in  1  access completes on the edge where mem_req && mem_ready.
out_valid  out  1  one-cycle pulse per completed instruction.
out_result  out  DATA_W  also drives prev_mem.
prev_mem  out  DATA_W  equal to out_result; forwarding path to execute.
out_rd  out  3.
out_wb_en  out  1.
mem_flags  out  4.
mem_flags_valid  out  1  one-cycle pulse on POP_FLAGS completion.
sp  out  ADDR_W  current stack pointer.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; sp=SP_INIT.
  - All outputs 0, including mem_req, stall and out_valid.
  - Reset mid-access drops mem_req immediately and discards the transaction; sp is not updated.
- FSM states: IDLE, BUSY.
- stall = (state==BUSY). It is registered-state based and has no combinational path from mem_ready.
- Acceptance: the instruction is accepted on the edge where state==IDLE && in_valid && !flush. It is captured into a holding register (op, addr, wdata, rd, wb_en).
- PASS/111:
  - State stays IDLE.
  - Next cycle: out_valid=1, out_result=in_alu_result, out_rd and out_wb_en from the instruction.
  - Latency is 1 cycle with no bubble.
- Memory op: state goes IDLE→BUSY. While BUSY, mem_req=1 and the address and data are held stable from the holding register.
  - LOAD: mem_addr=alu_result[ADDR_W-1:0], mem_we=0.
  - STORE: mem_addr=alu_result, mem_we=1, mem_wdata=store_data.
  - PUSH: mem_addr=sp, mem_we=1, mem_wdata=store_data. sp←sp-1 at completion.
  - PUSH_FLAGS: same as PUSH with mem_wdata={12'b0,in_flags}.
  - POP: mem_addr=sp+1, mem_we=0. sp←sp+1 at completion.
  - POP_FLAGS: same as POP; mem_flags←mem_rdata[3:0] and mem_flags_valid pulses.
- Completion, on the edge where BUSY && mem_ready:
  - state→IDLE.
  - Next cycle: out_valid=1.
  - out_result=mem_rdata for reads; out_result=addr/alu_result for writes, with out_wb_en forced 0 for writes.
  - Minimum memory latency is 2 cycles: 1 stall cycle with zero-wait memory, plus one stall cycle per wait state.
- Held outputs: out_result, out_rd, mem_flags and prev_mem hold their values between completions; only the pulses drop.
- sp arithmetic is modulo 2^ADDR_W:
  - PUSH at sp=0 gives 0xFFFF.
  - POP at 0xFFFF reads address 0 and sets sp=0.
- flush:
  - In IDLE: blocks acceptance that cycle.
  - In BUSY: the transaction still completes (bus protocol and sp update preserved), but out_valid, out_wb_en and mem_flags_valid are suppressed for that instruction. A flush seen on any BUSY cycle is latched until completion.
- Edge cases:
  - mem_ready while IDLE is ignored.
  - in_valid while BUSY is not accepted; upstream holds it under stall.
  - Back-to-back: an instruction presented in the cycle after completion is accepted immediately.

Decomposition:
- Package mem_stage_pkg holds:
  - the op encodings (OP_PASS…OP_PUSH_FLAGS);
  - state encodings;
  - DATA_W and FLAG_W=4.
- Sub-module stack_pointer holds the sp register:
  - inputs inc, dec, SP_INIT reset;
  - outputs sp and sp_plus1;
  - inc and dec are never asserted together.

Test Plan:
- PASS, alu_result=0x1234, rd=3, wb_en=1 → out_valid pulse next cycle with out_result=prev_mem=0x1234, rd=3; stall stays 0.
- STORE addr=0x0010 data=0xBEEF, mem_ready held 0 for 2 cycles → mem_req/we high for 3 cycles with addr 0x0010; stall 3 cycles; out_wb_en=0. A following LOAD of 0x0010 with memory model returns 0xBEEF on out_result.
- sp wrap and round-trip from reset (sp=0xFFFF):
  - PUSH 0xAAAA → write at 0xFFFF, sp=0xFFFE.
  - POP → read 0xFFFF, result 0xAAAA, sp=0xFFFF.
  - Force sp=0 via pushes, then PUSH → sp=0xFFFF.
- PUSH_FLAGS in_flags=4'b1010 then POP_FLAGS → mem_wdata=0x000A; mem_flags=4'b1010 with a single mem_flags_valid pulse.
- LOAD with flush asserted mid-BUSY → transaction completes on mem_ready; no out_valid. Assert rst_n=0 during a second BUSY → mem_req drops asynchronously, sp unchanged from SP_INIT/prior value, stall=0.
